// File: rtl/m_port_ultra_jarvis_hull_processor_if.sv
// Handshake and point/hull bus bundle for the Jarvis-march hull engine.
interface m_port_ultra_jarvis_hull_processor_if #(
  parameter int COORD_W = 8,
  parameter int MAX_PTS = 256,
  parameter int IDX_W   = $clog2(MAX_PTS)
);
  logic                           start;
  logic [IDX_W:0]                 SS;
  logic [MAX_PTS*2*COORD_W-1:0]   points;
  logic                           busy;
  logic                           done;
  logic [MAX_PTS*2*COORD_W-1:0]   hullPoints;
  logic [IDX_W:0]                 hullSize;
  logic                           overflow;
  logic [2:0]                     stateOutput;

  modport master (
    output start, SS, points,
    input  busy, done, hullPoints, hullSize, overflow, stateOutput
  );

  modport slave (
    input  start, SS, points,
    output busy, done, hullPoints, hullSize, overflow, stateOutput
  );
endinterface

// File: rtl/m_port_ultra_jarvis_hull_processor.sv
// Gift-wrapping convex-hull engine: walks the point bus one index per cycle
// and emits hull vertices counter-clockwise from the leftmost point.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE  (0) | waiting for start
// FIND_LEFT | scan all points for min x (then min y, then lowest index)
// EMIT  (2) | append cur to the hull, or flag overflow when full
// SCAN  (3) | sweep all points for the most clockwise candidate from cur
// CHECK (4) | stop if the candidate is back at the start coordinates
// DONE  (5) | one-cycle completion pulse
module m_port_ultra_jarvis_hull_processor #(
  parameter int COORD_W = 8,
  parameter int MAX_PTS = 256,
  parameter int IDX_W   = $clog2(MAX_PTS)
) (
  input logic CLK100MHZ,
  input logic CPU_RESETN,
  m_port_ultra_jarvis_hull_processor_if.slave bus
);
  localparam int PW = 2*COORD_W;
  localparam int CW = 2*COORD_W + 3;
  localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(MAX_PTS);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FIND_LEFT = 3'd1;
  localparam logic [2:0] S_EMIT      = 3'd2;
  localparam logic [2:0] S_SCAN      = 3'd3;
  localparam logic [2:0] S_CHECK     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]           state;
  logic [IDX_W:0]       n;
  logic [IDX_W-1:0]     idx, best, cur, cand;
  logic [PW-1:0]        start_pt;
  logic [MAX_PTS*PW-1:0] hull_pts;
  logic [IDX_W:0]       hull_size;
  logic                 ovf;

  logic [PW-1:0]        pt [MAX_PTS];
  logic [PW-1:0]        p_idx, p_best, p_cur, p_cand;
  logic [IDX_W:0]       n_req, cur_inc;
  logic                 last, better, replace;
  logic signed [COORD_W:0] ax, ay, bx, by;
  logic signed [CW-1:0] eax, eay, ebx, eby, cr, da, db;

  always_comb begin
    for (int i = 0; i < MAX_PTS; i++) pt[i] = bus.points[i*PW +: PW];
  end

  assign p_idx   = pt[idx];
  assign p_best  = pt[best];
  assign p_cur   = pt[cur];
  assign p_cand  = pt[cand];
  assign n_req   = (bus.SS > MAX_N) ? MAX_N : bus.SS;
  assign cur_inc = {1'b0, cur} + 1'b1;
  assign last    = ({1'b0, idx} == (n - 1'b1));

  // Lexicographic (x, y) minimum; strict compares keep the lowest index on ties.
  assign better = (idx == '0) ||
                  (p_idx[PW-1:COORD_W] <  p_best[PW-1:COORD_W]) ||
                  ((p_idx[PW-1:COORD_W] == p_best[PW-1:COORD_W]) &&
                   (p_idx[COORD_W-1:0] <  p_best[COORD_W-1:0]));

  always_comb begin
    ax  = $signed({1'b0, p_cand[PW-1:COORD_W]}) - $signed({1'b0, p_cur[PW-1:COORD_W]});
    ay  = $signed({1'b0, p_cand[COORD_W-1:0]})  - $signed({1'b0, p_cur[COORD_W-1:0]});
    bx  = $signed({1'b0, p_idx[PW-1:COORD_W]})  - $signed({1'b0, p_cur[PW-1:COORD_W]});
    by  = $signed({1'b0, p_idx[COORD_W-1:0]})   - $signed({1'b0, p_cur[COORD_W-1:0]});
    eax = CW'(ax);
    eay = CW'(ay);
    ebx = CW'(bx);
    eby = CW'(by);
    cr  = eax*eby - eay*ebx;
    da  = eax*eax + eay*eay;
    db  = ebx*ebx + eby*eby;
    // Right turn wins; on a collinear tie the farther point wins.
    replace = (cr < 0) || ((cr == 0) && ($unsigned(db) > $unsigned(da)));
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state     <= S_IDLE;
      n         <= '0;
      idx       <= '0;
      best      <= '0;
      cur       <= '0;
      cand      <= '0;
      start_pt  <= '0;
      hull_pts  <= '0;
      hull_size <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            n         <= n_req;
            hull_pts  <= '0;
            hull_size <= '0;
            ovf       <= 1'b0;
            idx       <= '0;
            best      <= '0;
            state     <= (n_req == '0) ? S_DONE : S_FIND_LEFT;
          end
        end
        S_FIND_LEFT: begin
          if (better) best <= idx;
          if (last) begin
            cur      <= better ? idx : best;
            start_pt <= better ? p_idx : p_best;
            state    <= S_EMIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_EMIT: begin
          if (hull_size == MAX_N) begin
            ovf   <= 1'b1;
            state <= S_DONE;
          end else begin
            hull_pts[int'(hull_size[IDX_W-1:0])*PW +: PW] <= p_cur;
            hull_size <= hull_size + 1'b1;
            cand      <= (cur_inc == n) ? '0 : cur_inc[IDX_W-1:0];
            idx       <= '0;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (replace) cand <= idx;
          if (last) state <= S_CHECK;
          else      idx   <= idx + 1'b1;
        end
        S_CHECK: begin
          // Coordinate compare so duplicates of the start point still terminate.
          if (p_cand == start_pt) begin
            state <= S_DONE;
          end else begin
            cur   <= cand;
            state <= S_EMIT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
  assign bus.hullPoints  = hull_pts;
  assign bus.hullSize    = hull_size;
  assign bus.overflow    = ovf;
  assign bus.stateOutput = state;
endmodule

// File: tb/tb_m_port_ultra_jarvis_hull_processor.sv
// Directed and random bench for the Jarvis hull engine with a result scoreboard.
module tb_m_port_ultra_jarvis_hull_processor;
  localparam int W  = 8;
  localparam int MP = 16;
  localparam int IW = 4;
  localparam int PW = 2*W;

  typedef struct packed {
    logic [31:0]        size;
    logic [31:0]        lat;
    logic [MP*PW-1:0]   hull;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m_port_ultra_jarvis_hull_processor_if #(.COORD_W(W), .MAX_PTS(MP), .IDX_W(IW)) hif();

  m_port_ultra_jarvis_hull_processor #(.COORD_W(W), .MAX_PTS(MP), .IDX_W(IW)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (hif)
  );

  int   n_pass = 0;
  int   n_total = 0;
  int   px [MP];
  int   py [MP];
  exp_t sbq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic clear_pts();
    for (int i = 0; i < MP; i++) begin
      px[i] = 0;
      py[i] = 0;
    end
  endtask

  task automatic drive_points();
    hif.points = '0;
    for (int i = 0; i < MP; i++) hif.points[i*PW +: PW] = {px[i][7:0], py[i][7:0]};
  endtask

  function automatic exp_t mk(input int size, input int lat,
                              input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input int x3, input int y3);
    exp_t e;
    int xs [4];
    int ys [4];
    xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
    ys[0] = y0; ys[1] = y1; ys[2] = y2; ys[3] = y3;
    e = '0;
    e.size = size;
    e.lat  = lat;
    for (int i = 0; i < size; i++) e.hull[i*PW +: PW] = {xs[i][7:0], ys[i][7:0]};
    return e;
  endfunction

  // Reference gift-wrap over the bench point arrays.
  task automatic model(input int n, output exp_t e);
    int best, cur, cand, h, sx, sy, ax, ay, bx, by, c, da, db;
    e = '0;
    if (n == 0) begin
      e.lat = 1;
      return;
    end
    best = 0;
    for (int i = 1; i < n; i++)
      if (px[i] < px[best] || (px[i] == px[best] && py[i] < py[best])) best = i;
    cur = best; sx = px[cur]; sy = py[cur]; h = 0;
    while (h < MP) begin
      e.hull[h*PW +: PW] = {px[cur][7:0], py[cur][7:0]};
      h++;
      cand = (cur + 1) % n;
      for (int j = 0; j < n; j++) begin
        ax = px[cand] - px[cur]; ay = py[cand] - py[cur];
        bx = px[j] - px[cur];    by = py[j] - py[cur];
        c  = ax*by - ay*bx;
        da = ax*ax + ay*ay;
        db = bx*bx + by*by;
        if (c < 0 || (c == 0 && db > da)) cand = j;
      end
      if (px[cand] == sx && py[cand] == sy) break;
      cur = cand;
    end
    e.size = h;
    e.lat  = n + h*(n+2) + 1;
  endtask

  task automatic run_case(input string tag, input int ss, input bit pulse_mid, input exp_t e_in);
    int   cyc;
    bit   busy_ok, pulsed;
    exp_t e;
    hif.SS = ss[IW:0];
    drive_points();
    sbq.push_back(e_in);
    @(negedge clk);
    hif.start = 1'b1;
    @(posedge clk); #1;
    hif.start = 1'b0;
    cyc = 1; busy_ok = 1'b1; pulsed = 1'b0;
    while (hif.done !== 1'b1 && cyc < 5000) begin
      if (hif.busy !== 1'b1) busy_ok = 1'b0;
      hif.start = 1'b0;
      if (pulse_mid && !pulsed && hif.stateOutput == 3'd3) begin
        hif.start = 1'b1;
        pulsed = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    hif.start = 1'b0;
    e = sbq.pop_front();
    chk($sformatf("%s_done", tag), 64'(hif.done), 64'd1);
    chk($sformatf("%s_latency", tag), 64'(cyc), 64'(e.lat));
    chk($sformatf("%s_busy", tag), 64'(busy_ok & hif.busy), 64'd1);
    chk($sformatf("%s_size", tag), 64'(hif.hullSize), 64'(e.size));
    chk($sformatf("%s_overflow", tag), 64'(hif.overflow), 64'd0);
    for (int i = 0; i < MP; i++)
      chk($sformatf("%s_slot%0d", tag, i), 64'(hif.hullPoints[i*PW +: PW]), 64'(e.hull[i*PW +: PW]));
    @(posedge clk); #1;
    chk($sformatf("%s_done_pulse", tag), 64'(hif.done), 64'd0);
    chk($sformatf("%s_idle", tag), 64'(hif.busy), 64'd0);
    chk($sformatf("%s_size_hold", tag), 64'(hif.hullSize), 64'(e.size));
  endtask

  task automatic set_square();
    clear_pts();
    px[0] = 10; py[0] = 10;
    px[1] = 50; py[1] = 10;
    px[2] = 50; py[2] = 50;
    px[3] = 10; py[3] = 50;
    px[4] = 30; py[4] = 30;
  endtask

  initial begin
    exp_t e, sq;
    int   wait_cyc;
    hif.start  = 1'b0;
    hif.SS     = '0;
    hif.points = '0;
    #12;
    chk("rst_busy",     64'(hif.busy), 64'd0);
    chk("rst_done",     64'(hif.done), 64'd0);
    chk("rst_size",     64'(hif.hullSize), 64'd0);
    chk("rst_overflow", 64'(hif.overflow), 64'd0);
    chk("rst_state",    64'(hif.stateOutput), 64'd0);
    chk("rst_hull",     64'(|hif.hullPoints), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    sq = mk(4, 34, 10,10, 50,10, 50,50, 10,50);
    set_square();
    run_case("square", 5, 1'b0, sq);

    clear_pts();
    px[0] = 0;  py[0] = 0;
    px[1] = 20; py[1] = 0;
    px[2] = 40; py[2] = 0;
    px[3] = 40; py[3] = 40;
    px[4] = 0;  py[4] = 40;
    run_case("collinear", 5, 1'b0, mk(4, 34, 0,0, 40,0, 40,40, 0,40));

    clear_pts();
    run_case("empty", 0, 1'b0, mk(0, 1, 0,0, 0,0, 0,0, 0,0));

    clear_pts();
    for (int i = 0; i < 3; i++) begin
      px[i] = 7;
      py[i] = 7;
    end
    run_case("identical", 3, 1'b0, mk(1, 9, 7,7, 0,0, 0,0, 0,0));

    set_square();
    run_case("square_restart", 5, 1'b1, sq);

    // Asynchronous reset in the middle of a SCAN.
    set_square();
    hif.SS = 5'd5;
    drive_points();
    @(negedge clk);
    hif.start = 1'b1;
    @(posedge clk); #1;
    hif.start = 1'b0;
    wait_cyc = 0;
    while (hif.stateOutput !== 3'd3 && wait_cyc < 100) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    chk("midrst_reached_scan", 64'(hif.stateOutput), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",  64'(hif.busy), 64'd0);
    chk("midrst_done",  64'(hif.done), 64'd0);
    chk("midrst_size",  64'(hif.hullSize), 64'd0);
    chk("midrst_hull",  64'(|hif.hullPoints), 64'd0);
    chk("midrst_state", 64'(hif.stateOutput), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_case("square_after_rst", 5, 1'b0, sq);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < MP; i++) begin
        px[i] = int'($urandom_range(0, 255));
        py[i] = int'($urandom_range(0, 255));
      end
      model(16, e);
      run_case($sformatf("random%0d", k), (k == 2) ? 20 : 16, 1'b0, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/m_port_ultra_jarvis_hull_processor.md
Name: m_port_ultra_jarvis_hull_processor

Overview:
Parametrised convex-hull engine for the portable-ultrasound point pipeline, succeeding the fixed 256x16-bit quickhull processor. It runs gift-wrapping (Jarvis march) over a flat point bus with configurable coordinate width and depth. It adds a start/busy/done handshake, explicit handling of degenerate, duplicate and collinear inputs, and an overflow flag. Output is the hull in counter-clockwise order, packed in the same format as the input.

Parameters:
COORD_W, 8, unsigned coordinate width; each point is 2*COORD_W bits.
MAX_PTS, 256, point capacity of the input and output buses.
IDX_W, $clog2(MAX_PTS), index width.

Ports:
CLK100MHZ  in  1  system clock
CPU_RESETN  in  1  asynchronous active-low reset
start  in  1  request; accepted only in IDLE
SS  in  IDX_W+1  point count; values above MAX_PTS are clamped to MAX_PTS
points  in  MAX_PTS*2*COORD_W  point i at [i*2W +: 2W]; x = upper W bits, y = lower W bits
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at completion
hullPoints  out  MAX_PTS*2*COORD_W  hull vertices, same packing; entries at and above hullSize are zero
hullSize  out  IDX_W+1  number of valid hull vertices
overflow  out  1  hull emission exceeded MAX_PTS
stateOutput  out  3  current state code (debug)

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset, at any time including mid-operation: state = IDLE; busy, done, overflow, hullSize and hullPoints all zero.
- points and SS must be held stable from start acceptance until done. Both are sampled combinationally; only SS is registered, as N = min(SS, MAX_PTS).
- Start acceptance: start=1 in IDLE latches N, clears hullPoints, hullSize and overflow, then goes to FIND_LEFT. start while busy is ignored.
- States and residency:
  - IDLE (0).
  - FIND_LEFT (1): N cycles, one index per cycle. Finds minimum x; ties go to minimum y, then lowest index. Result sets start_pt and cur.
  - EMIT (2): 1 cycle. Writes cur coordinates to slot hullSize and increments hullSize. If hullSize == MAX_PTS already, sets overflow and goes to DONE.
  - SCAN (3): N cycles. cand is initialised to (cur+1) mod N. For each j, compute c = cross(cand-cur, j-cur) as signed 2W+3 bits, with differences signed W+1 and dist = dx^2+dy^2 unsigned 2W+3 bits. Replace cand with j if c<0, or if c==0 and dist(j-cur) > dist(cand-cur).
  - CHECK (4): 1 cycle. If cand coordinates equal start_pt coordinates, go to DONE. Otherwise cur = cand and go to EMIT.
  - DONE (5): 1 cycle with done=1, then IDLE.
- Termination compares coordinates, not indices, so duplicate points cannot loop forever. All-identical input gives hullSize 1.
- Collinear boundary points strictly between hull vertices are excluded, because the farthest point wins on zero cross product.
- N=0: FIND_LEFT is skipped; DONE follows directly; hullSize=0.
- N=1: hullSize 1. N=2 distinct points: hullSize 2.
- Latency with h hull vertices (N≥1): the done pulse occurs N + h*(N+2) + 1 cycles after the acceptance edge.
- hullPoints, hullSize and overflow hold after done until the next accepted start or reset.

Test Plan:
- W=8, MAX_PTS=16; SS=5; points (10,10),(50,10),(50,50),(10,50),(30,30) -> hullSize=4; order (10,10),(50,10),(50,50),(10,50); slot 4 zero; done pulse 34 cycles after acceptance; busy high throughout.
- Collinear: (0,0),(20,0),(40,0),(40,40),(0,40) -> hullSize=4; (20,0) absent; first vertex (0,0), second (40,0).
- Degenerate: SS=0 -> done on the cycle after acceptance, hullSize=0. SS=3, all (7,7) -> hullSize=1, slot 0 = (7,7).
- Start pulsed again during SCAN of the square case -> ignored; result and latency identical to the first scenario. SS=20 -> clamped to 16.
- CPU_RESETN low mid-SCAN -> busy, done, hullSize and hullPoints zero immediately (asynchronous), state IDLE. A fresh start then reproduces the square result.
- Random 16-point sets checked against a software Jarvis model -> exact vertex sequence and hullSize match; overflow stays 0.
